pll_reset_sequencer: RTL



---
 rtl/pll_reset_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the PLL output clock domain.
// Holds the domain in reset until the synchronized PLL lock has been stable long enough.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET     | just out of resetb; leaves on the first edge
// WAIT_LOCK | filtering: counting consecutive synchronized lock samples
// HOLD      | lock filtered; counting the extra stable cycles before release
// RUN       | domain reset released, ready high
module pll_reset_sequencer #(
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 64
) (
  input  logic       clock_in,
  input  logic       resetb,
  input  logic       locked,
  output logic       reset_out,
  output logic       reset_out_n,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic [1:0] state
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  localparam logic [15:0] FILT_TC = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] HOLD_TC = 16'(HOLD_CYCLES - 1);

  logic        s1_q, s2_q;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  loss_q, loss_d;
  logic        loss_inc;
  logic        reset_q, reset_n_q, ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_inc = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (!s2_q) begin
          cnt_d = '0;
        end else if (cnt_q == FILT_TC) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_HOLD: begin
        if (!s2_q) begin
          state_d  = ST_WAIT;
          cnt_d    = '0;
          loss_inc = 1'b1;
        end else if (cnt_q == HOLD_TC) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (!s2_q) begin
          state_d  = ST_WAIT;
          cnt_d    = '0;
          loss_inc = 1'b1;
        end
      end
    endcase
  end

  // Saturates at 255; only resetb brings it back to zero.
  assign loss_d = (loss_inc && (loss_q != 8'hFF)) ? loss_q + 8'd1 : loss_q;

  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      loss_q    <= '0;
      reset_q   <= 1'b1;
      reset_n_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      s1_q      <= locked;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      reset_q   <= (state_d != ST_RUN);
      reset_n_q <= (state_d == ST_RUN);
      ready_q   <= (state_d == ST_RUN);
    end
  end

  assign reset_out       = reset_q;
  assign reset_out_n     = reset_n_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_q;
  assign state           = state_q;

endmodule
